// File: rtl/hsid_mse_comp.sv
// hsid_mse_comp: tracks the running minimum and maximum MSE (value plus library
// reference index) of one pixel across the HSI library. A pixel is armed by start,
// ends once the clamped library_size results have been accepted, then pulses done
// and holds the min/max result until the next start or reset.
module hsid_mse_comp #(
    parameter int WORD_WIDTH            = 32,
    parameter int HSI_LIBRARY_SIZE      = 16,
    parameter int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [HSI_LIBRARY_SIZE_ADDR:0]   library_size,
    input  logic [WORD_WIDTH-1:0]            mse_value,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_ref,
    input  logic                             mse_valid,
    output logic                             busy,
    output logic                             done,
    output logic [WORD_WIDTH-1:0]            min_mse_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_mse_ref,
    output logic [WORD_WIDTH-1:0]            max_mse_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] max_mse_ref
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int               CNT_W   = HSI_LIBRARY_SIZE_ADDR + 1;
    localparam logic [CNT_W-1:0] LIB_MAX = CNT_W'(HSI_LIBRARY_SIZE);

    // A requested size beyond the library depth is clamped to the library depth.
    function automatic logic [CNT_W-1:0] clamp_target(input logic [CNT_W-1:0] size);
        if (size > LIB_MAX)
            return LIB_MAX;
        else
            return size;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] start_target;
    logic             accept;
    logic             last_accept;

    assign start_target = clamp_target(library_size);

    // start has priority: a result arriving alongside start belongs to no pixel.
    assign accept      = (state == S_TRACK) && mse_valid && !start;
    assign last_accept = accept && ((count + CNT_W'(1)) == target);

    assign busy = (state == S_TRACK);
    assign done = (state == S_DONE);

    // Pixel sequencing: arm on start, count accepted results, one-cycle DONE, back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            target <= '0;
        end else if (start) begin
            state  <= (start_target == '0) ? S_DONE : S_TRACK;
            count  <= '0;
            target <= start_target;
        end else begin
            case (state)
                S_TRACK: begin
                    if (accept) begin
                        count <= count + CNT_W'(1);
                        if (last_accept)
                            state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_IDLE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Running min/max; strict compares so a tie keeps the earlier reference.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            min_mse_value <= '1;
            min_mse_ref   <= '0;
            max_mse_value <= '0;
            max_mse_ref   <= '0;
        end else if (accept) begin
            if (mse_value < min_mse_value) begin
                min_mse_value <= mse_value;
                min_mse_ref   <= mse_ref;
            end
            if (mse_value > max_mse_value) begin
                max_mse_value <= mse_value;
                max_mse_ref   <= mse_ref;
            end
        end
    end

endmodule

// File: tb/tb_hsid_mse_comp.sv
// Testbench for hsid_mse_comp: table-driven pixel vectors with hand-derived expected
// results, hand-written restart/ignore/reset sequences, and randomized pixels checked
// against a running min/max model of the accepted result stream.
module tb_hsid_mse_comp;

    localparam int W  = 32;
    localparam int LS = 16;
    localparam int AW = $clog2(LS);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   library_size;
    logic [W-1:0]  mse_value;
    logic [AW-1:0] mse_ref;
    logic          mse_valid;
    logic          busy;
    logic          done;
    logic [W-1:0]  min_mse_value;
    logic [AW-1:0] min_mse_ref;
    logic [W-1:0]  max_mse_value;
    logic [AW-1:0] max_mse_ref;

    hsid_mse_comp #(
        .WORD_WIDTH(W),
        .HSI_LIBRARY_SIZE(LS),
        .HSI_LIBRARY_SIZE_ADDR(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .library_size(library_size),
        .mse_value(mse_value),
        .mse_ref(mse_ref),
        .mse_valid(mse_valid),
        .busy(busy),
        .done(done),
        .min_mse_value(min_mse_value),
        .min_mse_ref(min_mse_ref),
        .max_mse_value(max_mse_value),
        .max_mse_ref(max_mse_ref)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_total = 0;

    // Count done cycles away from the active edge.
    always @(negedge clk) if (done === 1'b1) done_total++;

    typedef struct {
        int                   lsz;
        int                   n;
        int                   gap;
        logic [15:0][W-1:0]   vals;
        logic [15:0][AW-1:0]  refs;
        logic [W-1:0]         e_min;
        logic [AW-1:0]        e_min_ref;
        logic [W-1:0]         e_max;
        logic [AW-1:0]        e_max_ref;
    } vec_t;

    vec_t vecs [6];

    logic [W-1:0]  cur_vals [16];
    logic [AW-1:0] cur_refs [16];

    // Reference model state: running min/max over the accepted results of a pixel.
    logic [W-1:0]  m_min;
    logic [AW-1:0] m_min_ref;
    logic [W-1:0]  m_max;
    logic [AW-1:0] m_max_ref;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_min = '1; m_min_ref = '0; m_max = '0; m_max_ref = '0;
    endtask

    task automatic model_accept(input logic [W-1:0] v, input logic [AW-1:0] r);
        if (v < m_min) begin m_min = v; m_min_ref = r; end
        if (v > m_max) begin m_max = v; m_max_ref = r; end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " min"},     min_mse_value, m_min);
        chk({tag, " min_ref"}, W'(min_mse_ref), W'(m_min_ref));
        chk({tag, " max"},     max_mse_value, m_max);
        chk({tag, " max_ref"}, W'(max_mse_ref), W'(m_max_ref));
    endtask

    // Start a pixel and feed n results from cur_vals/cur_refs; gap<0 means random gaps.
    task automatic run_pixel(input int lsz, input int n, input int gap);
        int d0;
        int g;
        d0 = done_total;
        model_reset();
        start = 1'b1; library_size = (AW+1)'(lsz); mse_valid = 1'b0;
        tick();
        start = 1'b0;
        if (n == 0) begin
            chk("empty done", W'(done), 1);
            chk("empty busy", W'(busy), 0);
        end
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) tick();
            mse_valid = 1'b1; mse_value = cur_vals[i]; mse_ref = cur_refs[i];
            tick();
            mse_valid = 1'b0;
            model_accept(cur_vals[i], cur_refs[i]);
            chk_model("live");
            if (i < n - 1) chk("busy mid", W'(busy), 1);
            else           chk("done after last", W'(done), 1);
        end
        tick();
        chk("done one cycle", W'(done), 0);
        chk("idle busy", W'(busy), 0);
        chk("single done", W'(done_total - d0), 1);
    endtask

    task automatic load_vec(input int idx);
        for (int i = 0; i < 16; i++) begin
            cur_vals[i] = vecs[idx].vals[i];
            cur_refs[i] = vecs[idx].refs[i];
        end
    endtask

    initial begin
        int d0;
        int lsz;
        int tgt;

        rst = 1'b1; start = 1'b0; library_size = '0;
        mse_value = '0; mse_ref = '0; mse_valid = 1'b0;

        // Vector table (expected values derived by hand from the min/max rules).
        for (int v = 0; v < 6; v++) begin
            vecs[v].vals = '0; vecs[v].refs = '0; vecs[v].gap = 0;
        end
        vecs[0].lsz = 4; vecs[0].n = 4;
        vecs[0].vals[0] = 50; vecs[0].vals[1] = 20; vecs[0].vals[2] = 90; vecs[0].vals[3] = 20;
        vecs[0].refs[0] = 1;  vecs[0].refs[1] = 2;  vecs[0].refs[2] = 3;  vecs[0].refs[3] = 4;
        vecs[0].e_min = 20; vecs[0].e_min_ref = 2; vecs[0].e_max = 90; vecs[0].e_max_ref = 3;

        vecs[1].lsz = 3; vecs[1].n = 3; vecs[1].gap = 2;
        vecs[1].vals[0] = 7; vecs[1].vals[1] = 7; vecs[1].vals[2] = 7;
        vecs[1].refs[0] = 5; vecs[1].refs[1] = 6; vecs[1].refs[2] = 7;
        vecs[1].e_min = 7; vecs[1].e_min_ref = 5; vecs[1].e_max = 7; vecs[1].e_max_ref = 5;

        vecs[2].lsz = 0; vecs[2].n = 0;
        vecs[2].e_min = '1; vecs[2].e_min_ref = 0; vecs[2].e_max = 0; vecs[2].e_max_ref = 0;

        vecs[3].lsz = LS + 5; vecs[3].n = LS;
        for (int i = 0; i < 16; i++) begin
            vecs[3].vals[i] = W'(1000 - 7 * i);
            vecs[3].refs[i] = AW'(i);
        end
        vecs[3].e_min = 895; vecs[3].e_min_ref = 15; vecs[3].e_max = 1000; vecs[3].e_max_ref = 0;

        vecs[4].lsz = 2; vecs[4].n = 2;
        vecs[4].vals[0] = '1; vecs[4].vals[1] = 0;
        vecs[4].refs[0] = 3;  vecs[4].refs[1] = 4;
        vecs[4].e_min = 0; vecs[4].e_min_ref = 4; vecs[4].e_max = '1; vecs[4].e_max_ref = 3;

        vecs[5].lsz = 1; vecs[5].n = 1;
        vecs[5].vals[0] = 0; vecs[5].refs[0] = 6;
        vecs[5].e_min = 0; vecs[5].e_min_ref = 6; vecs[5].e_max = 0; vecs[5].e_max_ref = 0;

        // Reset state
        tick(); tick();
        chk("rst busy", W'(busy), 0);
        chk("rst done", W'(done), 0);
        chk("rst min", min_mse_value, '1);
        chk("rst max", max_mse_value, 0);
        chk("rst min_ref", W'(min_mse_ref), 0);
        chk("rst max_ref", W'(max_mse_ref), 0);
        rst = 1'b0;
        tick();

        // Table-driven pixels
        for (int v = 0; v < 6; v++) begin
            load_vec(v);
            run_pixel(vecs[v].lsz, vecs[v].n, vecs[v].gap);
            chk($sformatf("vec%0d min", v),     min_mse_value,     vecs[v].e_min);
            chk($sformatf("vec%0d min_ref", v), W'(min_mse_ref),   W'(vecs[v].e_min_ref));
            chk($sformatf("vec%0d max", v),     max_mse_value,     vecs[v].e_max);
            chk($sformatf("vec%0d max_ref", v), W'(max_mse_ref),   W'(vecs[v].e_max_ref));
        end

        // Restart after 2 of 4 results: the partial pixel gives no done
        d0 = done_total;
        start = 1'b1; library_size = 4; tick(); start = 1'b0;
        mse_valid = 1'b1; mse_value = 0; mse_ref = 9; tick();
        mse_value = 500; mse_ref = 10; tick();
        mse_valid = 1'b0;
        cur_vals[0] = 9; cur_vals[1] = 3; cur_vals[2] = 8; cur_vals[3] = 1;
        for (int i = 0; i < 4; i++) cur_refs[i] = AW'(i);
        run_pixel(4, 4, 0);
        chk("restart min", min_mse_value, 1);
        chk("restart min_ref", W'(min_mse_ref), 3);
        chk("restart max", max_mse_value, 9);
        chk("restart max_ref", W'(max_mse_ref), 0);
        chk("restart dones", W'(done_total - d0), 1);

        // mse_valid in IDLE is ignored; result held
        mse_valid = 1'b1; mse_value = 0; mse_ref = 12; tick(); tick();
        mse_valid = 1'b0;
        chk("idle ignore min", min_mse_value, 1);
        chk("idle ignore max", max_mse_value, 9);

        // mse_valid during DONE is ignored
        start = 1'b1; library_size = 2; tick(); start = 1'b0;
        mse_valid = 1'b1; mse_value = 100; mse_ref = 1; tick();
        mse_value = 200; mse_ref = 2; tick();
        chk("done seq done", W'(done), 1);
        mse_value = 0; mse_ref = 9; tick();
        mse_value = 300; tick();
        mse_valid = 1'b0;
        chk("done ignore min", min_mse_value, 100);
        chk("done ignore min_ref", W'(min_mse_ref), 1);
        chk("done ignore max", max_mse_value, 200);
        chk("done ignore max_ref", W'(max_mse_ref), 2);

        // start together with mse_valid: that result is dropped
        start = 1'b1; library_size = 1; mse_valid = 1'b1; mse_value = 5; mse_ref = 3;
        tick();
        start = 1'b0;
        chk("start drop min", min_mse_value, '1);
        chk("start drop busy", W'(busy), 1);
        mse_value = 40; mse_ref = 4; tick();
        mse_valid = 1'b0;
        chk("start drop done", W'(done), 1);
        chk("start drop min2", min_mse_value, 40);
        chk("start drop max_ref", W'(max_mse_ref), 4);
        tick();

        // rst mid-TRACK aborts with no done
        d0 = done_total;
        start = 1'b1; library_size = 4; tick(); start = 1'b0;
        mse_valid = 1'b1; mse_value = 11; mse_ref = 1; tick();
        mse_value = 22; mse_ref = 2; tick();
        rst = 1'b1; mse_value = 33; tick();
        rst = 1'b0; mse_value = 44; tick(); tick();
        mse_valid = 1'b0; tick(); tick();
        chk("rst mid busy", W'(busy), 0);
        chk("rst mid min", min_mse_value, '1);
        chk("rst mid max", max_mse_value, 0);
        chk("rst mid max_ref", W'(max_mse_ref), 0);
        chk("rst mid no done", W'(done_total - d0), 0);

        // Randomized pixels against the running min/max model
        for (int p = 0; p < 40; p++) begin
            lsz = int'($urandom_range(0, LS + 5));
            tgt = (lsz > LS) ? LS : lsz;
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 5))
                    0:       cur_vals[i] = '1;
                    1:       cur_vals[i] = '0;
                    2, 3:    cur_vals[i] = W'($urandom_range(0, 15));
                    default: cur_vals[i] = $urandom;
                endcase
                cur_refs[i] = AW'($urandom_range(0, LS - 1));
            end
            run_pixel(lsz, tgt, -1);
            chk("rand final min", min_mse_value, m_min);
            chk("rand final max", max_mse_value, m_max);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
